// File: rtl/fc_pkg.sv
// Constants and state encoding shared between the FC input collector and the FC top module.
package fc_pkg;

    localparam int unsigned FC_INPUT_SIZE = 120;
    localparam int unsigned WORD_SIZE     = 16;
    localparam int unsigned IDX_WIDTH     = 7;

    typedef logic [WORD_SIZE-1:0] fc_word_t;

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } fc_state_e;

    // True when the given word index is the final slot of a frame.
    function automatic logic is_last_idx(input logic [IDX_WIDTH-1:0] idx);
        return idx == IDX_WIDTH'(FC_INPUT_SIZE - 1);
    endfunction

endpackage

// File: rtl/Edge_Detector.sv
// Rising-edge detector: registers the previous level of sig_i; rise_c is high
// on the cycle the input is 1 and the last sampled level was 0.
module Edge_Detector (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_c
);

    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= sig_i;
    end

    assign rise_c = sig_i & ~prev_q;

endmodule

// File: rtl/fc_input_collector.sv
// Collects a stream of feature words into the parallel FC input vector and
// holds it until the FC stage signals completion with a rising FC_done.
module fc_input_collector
    import fc_pkg::*;
(
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       in_valid,
    input  logic [WORD_SIZE-1:0]                       in_data,
    input  logic                                       in_last,
    output logic                                       in_ready,
    input  logic                                       FC_done,
    output logic [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0]    FC_inputs,
    output logic                                       CNN_ready,
    output logic                                       frame_error,
    output logic [IDX_WIDTH-1:0]                       word_count
);

    fc_state_e state_q, state_d;

    logic [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0] buf_q, buf_d;
    logic [IDX_WIDTH-1:0]                    count_q, count_d;
    logic                                    err_q, err_d;
    logic                                    done_rise;
    logic                                    accept;
    logic                                    at_last_idx;

    Edge_Detector u_done_edge (
        .clk    (clk),
        .rst_n  (rst),
        .sig_i  (FC_done),
        .rise_c (done_rise)
    );

    assign accept      = in_valid & in_ready;
    assign at_last_idx = is_last_idx(count_q);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= CLEAR;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CLEAR:   state_d = COLLECT;
            COLLECT: if (accept && (at_last_idx || in_last)) state_d = HOLD;
            HOLD:    if (done_rise) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Handshake outputs depend on the state register only
    always_comb begin
        in_ready  = 1'b0;
        CNN_ready = 1'b0;
        unique case (state_q)
            COLLECT: in_ready  = 1'b1;
            HOLD:    CNN_ready = 1'b1;
            default: ;
        endcase
    end

    // Buffer, count and error next-state; frozen outside CLEAR/COLLECT
    always_comb begin
        buf_d   = buf_q;
        count_d = count_q;
        err_d   = err_q;
        if (state_q == CLEAR) begin
            buf_d   = '0;
            count_d = '0;
            err_d   = 1'b0;
        end else if (accept) begin
            for (int i = 0; i < FC_INPUT_SIZE; i++) begin
                if (count_q == IDX_WIDTH'(i)) buf_d[i] = in_data;
            end
            count_d = count_q + IDX_WIDTH'(1);
            // Long frame: last slot filled without in_last; short frame: in_last early
            if (at_last_idx) err_d = ~in_last;
            else if (in_last) err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            buf_q   <= buf_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign FC_inputs   = buf_q;
    assign word_count  = count_q;
    assign frame_error = err_q;

endmodule

// File: tb/tb_fc_input_collector.sv
// Directed bench for fc_input_collector: frame assembly, hold/release,
// short/long frames, asynchronous reset and held-high FC_done.
module tb_fc_input_collector;
    import fc_pkg::*;

    logic                                    clk;
    logic                                    rst;
    logic                                    in_valid;
    logic [WORD_SIZE-1:0]                    in_data;
    logic                                    in_last;
    logic                                    in_ready;
    logic                                    FC_done;
    logic [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0] FC_inputs;
    logic                                    CNN_ready;
    logic                                    frame_error;
    logic [IDX_WIDTH-1:0]                    word_count;

    logic [0:FC_INPUT_SIZE-1][WORD_SIZE-1:0] exp_vec;

    int checks   = 0;
    int failures = 0;

    fc_input_collector dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .FC_done     (FC_done),
        .FC_inputs   (FC_inputs),
        .CNN_ready   (CNN_ready),
        .frame_error (frame_error),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_vec(input string tag);
        checks++;
        assert (FC_inputs === exp_vec) else begin
            failures++;
            $error("FAIL %s: observed [0]=%0h [119]=%0h required [0]=%0h [119]=%0h",
                   tag, FC_inputs[0], FC_inputs[119], exp_vec[0], exp_vec[119]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Streams n words base, base+1, ...; in_last on word index last_at (-1 = never)
    task automatic send_frame(input int n, input logic [WORD_SIZE-1:0] base, input int last_at);
        for (int k = 0; k < n; k++) begin
            int t;
            t = 0;
            while (!in_ready && t < 10) begin
                step();
                t++;
            end
            if (t == 10) chk("in_ready_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = base + WORD_SIZE'(k);
            in_last  = (k == last_at);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_done();
        FC_done = 1'b1;
        step();
        FC_done = 1'b0;
        step();
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        FC_done  = 1'b0;

        // Reset values
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_cnn_ready", 64'(CNN_ready), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        chk("rst_frame_error", 64'(frame_error), 64'd0);
        exp_vec = '0;
        chk_vec("rst_fc_inputs");
        rst = 1'b1;
        chk("clear_in_ready", 64'(in_ready), 64'd0);
        step();
        chk("collect_in_ready", 64'(in_ready), 64'd1);

        // Full frame 1..120
        send_frame(120, 16'd1, 119);
        chk("full_cnn_ready", 64'(CNN_ready), 64'd1);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_word0", 64'(FC_inputs[0]), 64'd1);
        chk("full_word119", 64'(FC_inputs[119]), 64'd120);
        chk("full_frame_error", 64'(frame_error), 64'd0);
        chk("full_word_count", 64'(word_count), 64'd120);
        for (int i = 0; i < 120; i++) exp_vec[i] = WORD_SIZE'(i + 1);
        chk_vec("full_vector");

        // HOLD for 50 cycles with upstream pushing
        in_valid = 1'b1;
        in_data  = 16'hDEAD;
        for (int i = 0; i < 50; i++) step();
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        chk("hold_cnn_ready", 64'(CNN_ready), 64'd1);
        chk_vec("hold_vector");
        in_valid = 1'b0;
        FC_done  = 1'b1;
        step();
        chk("release_cnn_ready", 64'(CNN_ready), 64'd0);
        chk("release_in_ready", 64'(in_ready), 64'd0);
        FC_done = 1'b0;
        step();
        chk("release_in_ready_next", 64'(in_ready), 64'd1);
        chk("release_word_count", 64'(word_count), 64'd0);
        exp_vec = '0;
        chk_vec("release_cleared");

        // Short frame: 10 words of 0x0AAA
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            in_data  = 16'h0AAA;
            in_last  = (k == 9);
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("short_cnn_ready", 64'(CNN_ready), 64'd1);
        chk("short_frame_error", 64'(frame_error), 64'd1);
        chk("short_word_count", 64'(word_count), 64'd10);
        for (int i = 0; i < 10; i++) exp_vec[i] = 16'h0AAA;
        chk_vec("short_vector");
        pulse_done();

        // Long frame: 120 words without in_last, 121st stalls
        send_frame(120, 16'h1000, -1);
        chk("long_cnn_ready", 64'(CNN_ready), 64'd1);
        chk("long_frame_error", 64'(frame_error), 64'd1);
        chk("long_word_count", 64'(word_count), 64'd120);
        chk("long_word0", 64'(FC_inputs[0]), 64'h1000);
        chk("long_word119", 64'(FC_inputs[119]), 64'h1077);
        in_valid = 1'b1;
        in_data  = 16'h1078;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) step();
        chk("long_stall_in_ready", 64'(in_ready), 64'd0);
        chk("long_stall_word0", 64'(FC_inputs[0]), 64'h1000);
        FC_done = 1'b1;
        step();
        chk("long_clear_cnn_ready", 64'(CNN_ready), 64'd0);
        FC_done = 1'b0;
        step();
        chk("long_collect_count", 64'(word_count), 64'd0);
        chk("long_collect_in_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("surplus_word0", 64'(FC_inputs[0]), 64'h1078);
        chk("surplus_word_count", 64'(word_count), 64'd1);
        chk("surplus_frame_error", 64'(frame_error), 64'd1);
        chk("surplus_cnn_ready", 64'(CNN_ready), 64'd1);
        pulse_done();

        // Asynchronous reset mid-frame
        send_frame(60, 16'h0500, -1);
        chk("mid_word_count", 64'(word_count), 64'd60);
        in_valid = 1'b1;
        in_data  = 16'h0600;
        #2;
        rst = 1'b0;
        #1;
        chk("async_in_ready", 64'(in_ready), 64'd0);
        chk("async_cnn_ready", 64'(CNN_ready), 64'd0);
        chk("async_word_count", 64'(word_count), 64'd0);
        exp_vec = '0;
        chk_vec("async_cleared");
        in_valid = 1'b0;
        step();
        rst = 1'b1;
        chk("post_rst_clear", 64'(in_ready), 64'd0);
        step();
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_word_count", 64'(word_count), 64'd0);

        // FC_done held high across a complete new frame
        send_frame(120, 16'h2000, 119);
        chk("held_a_cnn_ready", 64'(CNN_ready), 64'd1);
        FC_done = 1'b1;
        step();
        chk("held_a_release", 64'(CNN_ready), 64'd0);
        step();
        send_frame(120, 16'h3000, 119);
        for (int i = 0; i < 5; i++) step();
        chk("held_b_cnn_ready", 64'(CNN_ready), 64'd1);
        chk("held_b_word0", 64'(FC_inputs[0]), 64'h3000);
        chk("held_b_word119", 64'(FC_inputs[119]), 64'h3077);
        chk("held_b_frame_error", 64'(frame_error), 64'd0);
        FC_done = 1'b0;
        step();
        chk("held_b_after_fall", 64'(CNN_ready), 64'd1);
        FC_done = 1'b1;
        step();
        chk("held_b_new_rise", 64'(CNN_ready), 64'd0);
        FC_done = 1'b0;
        step();
        chk("held_b_collect", 64'(in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
